// File: rtl/clint_mmio_pkg.sv
// Shared definitions for the core-local interruptor.
// Holds the register-map byte offsets, the mtimecmp reset value and the
// handshake FSM state type used by clint_mmio.
package clint_mmio_pkg;

    // Byte offsets of the register map (32-bit view)
    localparam logic [15:0] CLINT_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_SSIP     = 16'h0004;
    localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

    // All ones keeps the timer interrupt quiet until software programs it
    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        StIdle,
        StAck
    } clint_state_e;

endpackage

// File: rtl/clint_mmio_mtime_counter.sv
// Free-running 64-bit mtime counter with prescaler and byte-lane writes.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   wr_en_i       write strobe for the counter (one cycle per accepted write)
//   be_i          byte-lane enables, one per byte of the 64-bit counter
//   wdata_i       write data aligned to the 64-bit counter
//   mtime_o       current counter value
module clint_mmio_mtime_counter #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [7:0]  be_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PreW-1:0] pre_q, pre_d;
    logic [63:0]     time_q, time_d;
    logic            tick;
    logic            write;

    assign tick  = (pre_q == PreW'(PRESCALE - 1));
    assign write = wr_en_i && (|be_i);

    always_comb begin
        pre_d  = tick ? '0 : pre_q + PreW'(1);
        time_d = tick ? time_q + 64'd1 : time_q;
        // A write freezes the whole counter for this cycle and restarts the prescaler
        if (write) begin
            pre_d  = '0;
            time_d = time_q;
            for (int b = 0; b < 8; b++) begin
                if (be_i[b]) begin
                    time_d[8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            time_q <= '0;
        end else begin
            pre_q  <= pre_d;
            time_q <= time_d;
        end
    end

    assign mtime_o = time_q;

endmodule

// File: rtl/clint_mmio.sv
// Memory-mapped core-local interruptor (msip, ssip, mtime, mtimecmp).
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   rd_en, wr_en       request strobes, held by the requester until ack
//   addr               word-aligned byte offset into the block
//   wr_data, byte_en   write data and per-byte lane enables
//   rd_data            read data, valid while ack is high
//   ack, err           one-cycle completion pulse; err flags an unmapped offset
//   msip, ssip         software interrupt pending bits
//   mtime, mtimecmp    timer and compare registers for the CSR unit
module clint_mmio
    import clint_mmio_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned ADDR_SIZE = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_SIZE-1:0]   addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   ack,
    output logic                   err,
    output logic                   msip,
    output logic                   ssip,
    output logic [63:0]            mtime,
    output logic [63:0]            mtimecmp
);

    clint_state_e         state_q;
    logic                 ack_q, err_q, msip_q, ssip_q;
    logic [DATA_SIZE-1:0] rd_data_q;
    logic [63:0]          mtimecmp_q;

    logic                 req;
    logic                 sel_msip, sel_ssip, sel_cmp, sel_time, mapped;
    logic [7:0]           be64;
    logic [63:0]          wdata64, rd64, cmp_wr, mtime_w;
    logic [DATA_SIZE-1:0] rd_word;

    assign req      = (state_q == StIdle) && (rd_en || wr_en);
    assign sel_msip = (addr == ADDR_SIZE'(CLINT_MSIP));
    assign sel_ssip = (addr == ADDR_SIZE'(CLINT_SSIP));
    assign mapped   = sel_msip || sel_ssip || sel_cmp || sel_time;

    // Bus-width specific decode: lanes are steered onto the 64-bit registers
    if (DATA_SIZE == 64) begin : g_bus64
        assign sel_cmp  = (addr == ADDR_SIZE'(CLINT_MTIMECMP));
        assign sel_time = (addr == ADDR_SIZE'(CLINT_MTIME));
        assign be64     = byte_en;
        assign wdata64  = wr_data;
        assign rd_word  = rd64;
    end else begin : g_bus32
        logic cmp_hi, time_hi, hi;
        assign cmp_hi   = (addr == ADDR_SIZE'(CLINT_MTIMECMP + 16'h4));
        assign time_hi  = (addr == ADDR_SIZE'(CLINT_MTIME + 16'h4));
        assign hi       = cmp_hi || time_hi;
        assign sel_cmp  = (addr == ADDR_SIZE'(CLINT_MTIMECMP)) || cmp_hi;
        assign sel_time = (addr == ADDR_SIZE'(CLINT_MTIME)) || time_hi;
        assign be64     = hi ? {byte_en, 4'b0000} : {4'b0000, byte_en};
        assign wdata64  = {wr_data, wr_data};
        assign rd_word  = hi ? rd64[63:32] : rd64[31:0];
    end

    // Read mux; unmapped offsets read zero
    always_comb begin
        rd64 = '0;
        if (sel_msip) begin
            rd64[0] = msip_q;
        end else if (sel_ssip) begin
            rd64[0] = ssip_q;
        end else if (sel_cmp) begin
            rd64 = mtimecmp_q;
        end else if (sel_time) begin
            rd64 = mtime_w;
        end
    end

    always_comb begin
        cmp_wr = mtimecmp_q;
        for (int b = 0; b < 8; b++) begin
            if (be64[b]) begin
                cmp_wr[8*b +: 8] = wdata64[8*b +: 8];
            end
        end
    end

    clint_mmio_mtime_counter #(
        .PRESCALE (PRESCALE)
    ) u_mtime_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .wr_en_i (req && wr_en && sel_time),
        .be_i    (be64),
        .wdata_i (wdata64),
        .mtime_o (mtime_w)
    );

    // Handshake FSM; read data is captured before any write so rd+wr returns the old value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            msip_q     <= 1'b0;
            ssip_q     <= 1'b0;
            mtimecmp_q <= MTIMECMP_RESET;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        state_q   <= StAck;
                        ack_q     <= 1'b1;
                        err_q     <= !mapped;
                        rd_data_q <= rd_word;
                        if (wr_en) begin
                            if (sel_msip && be64[0]) msip_q <= wdata64[0];
                            if (sel_ssip && be64[0]) ssip_q <= wdata64[0];
                            if (sel_cmp)             mtimecmp_q <= cmp_wr;
                        end
                    end
                end
                StAck: begin
                    state_q   <= StIdle;
                    ack_q     <= 1'b0;
                    err_q     <= 1'b0;
                    rd_data_q <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign msip     = msip_q;
    assign ssip     = ssip_q;
    assign mtime    = mtime_w;
    assign mtimecmp = mtimecmp_q;

endmodule
